// File: rtl/mem_initiator.sv
// Burst memory initiator: turns one client command into cmd_len+1 single-beat
// transfers on separate memory address/data channels, one beat outstanding at a time.
module mem_initiator #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // client command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // client write data
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  // client read return
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  // memory write address / data
  output logic              mi_addr_valid,
  input  logic              mi_addr_ready,
  output logic [ADDR_W-1:0] mi_addr,
  output logic              mi_data_valid,
  input  logic              mi_data_ready,
  output logic [WIDTH-1:0]  mi_data,
  // memory read address / data
  output logic              mo_addr_valid,
  input  logic              mo_addr_ready,
  output logic [ADDR_W-1:0] mo_addr,
  input  logic              mo_data_valid,
  output logic              mo_data_ready,
  input  logic [WIDTH-1:0]  mo_data,
  // status
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; a raised valid holds its payload
  // stable until that transfer.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_FETCH = 3'd1;
  localparam logic [2:0] S_W_ADDR  = 3'd2;
  localparam logic [2:0] S_W_DATA  = 3'd3;
  localparam logic [2:0] S_R_ADDR  = 3'd4;
  localparam logic [2:0] S_R_DATA  = 3'd5;
  localparam logic [2:0] S_R_RET   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  data_q;
  // Holds cmd_ready low until the first edge after reset is released.
  logic              init_done_q;

  logic cmd_xfer;
  logic wr_xfer;
  logic mo_data_xfer;
  logic beat_end;
  logic last_beat;

  assign cmd_ready     = (state_q == S_IDLE) && init_done_q;
  assign wr_ready      = (state_q == S_W_FETCH);
  assign mi_addr_valid = (state_q == S_W_ADDR);
  assign mi_data_valid = (state_q == S_W_DATA);
  assign mo_addr_valid = (state_q == S_R_ADDR);
  assign mo_data_ready = (state_q == S_R_DATA);
  assign rd_valid      = (state_q == S_R_RET);
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

  // One address and one data register serve both directions.
  assign mi_addr = addr_q;
  assign mo_addr = addr_q;
  assign mi_data = data_q;
  assign rd_data = data_q;

  assign cmd_xfer     = cmd_valid && cmd_ready;
  assign wr_xfer      = wr_valid && wr_ready;
  assign mo_data_xfer = mo_data_valid && mo_data_ready;
  assign beat_end     = (mi_data_valid && mi_data_ready) || (rd_valid && rd_ready);
  assign last_beat    = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_xfer) state_d = cmd_write ? S_W_FETCH : S_R_ADDR;
      end
      S_W_FETCH: begin
        if (wr_valid) state_d = S_W_ADDR;
      end
      S_W_ADDR: begin
        if (mi_addr_ready) state_d = S_W_DATA;
      end
      S_W_DATA: begin
        if (mi_data_ready) state_d = last_beat ? S_IDLE : S_W_FETCH;
      end
      S_R_ADDR: begin
        if (mo_addr_ready) state_d = S_R_DATA;
      end
      S_R_DATA: begin
        if (mo_data_valid) state_d = S_R_RET;
      end
      S_R_RET: begin
        if (rd_ready) state_d = last_beat ? S_IDLE : S_R_ADDR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= 1'b1;
      if (cmd_xfer) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        cnt_q  <= '0;
      end
      if (wr_xfer) data_q <= wr_data;
      if (mo_data_xfer) data_q <= mo_data;
      // Address wraps naturally at 2^ADDR_W.
      if (beat_end && !last_beat) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  a_one_channel_active: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cmd_ready, wr_ready, mi_addr_valid, mi_data_valid,
              mo_addr_valid, mo_data_ready, rd_valid}));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_ready |-> !busy);

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: table of bursts with hand-computed endpoints,
// per-beat expected queues, random stalls, and a mid-burst reset sequence.
module tb_mem_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       mi_addr_valid, mi_addr_ready;
  logic [7:0] mi_addr;
  logic       mi_data_valid, mi_data_ready;
  logic [7:0] mi_data;
  logic       mo_addr_valid, mo_addr_ready;
  logic [7:0] mo_addr;
  logic       mo_data_valid, mo_data_ready;
  logic [7:0] mo_data;
  logic       busy;
  logic [2:0] dbg_state;

  mem_initiator #(.WIDTH(8), .ADDR_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mi_addr_valid(mi_addr_valid), .mi_addr_ready(mi_addr_ready), .mi_addr(mi_addr),
    .mi_data_valid(mi_data_valid), .mi_data_ready(mi_data_ready), .mi_data(mi_data),
    .mo_addr_valid(mo_addr_valid), .mo_addr_ready(mo_addr_ready), .mo_addr(mo_addr),
    .mo_data_valid(mo_data_valid), .mo_data_ready(mo_data_ready), .mo_data(mo_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] dbase;
    logic [7:0] last_addr;
    logic [7:0] first_d;
    logic [7:0] last_d;
    int         cycles;    // busy cycles without stalls, 0 = not checked
    logic       stall;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard expected queues (main pushes, monitor walks an index).
  logic [7:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];
  logic [7:0] exp_ra_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] wr_src_q[$];
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];
  int wa_idx = 0, wd_idx = 0, ra_idx = 0, rd_idx = 0, wr_idx = 0;
  int n_wa = 0, n_wd = 0, n_rd = 0;

  logic drv_en = 1'b0;
  logic mon_en = 1'b0;
  logic stall_en = 1'b0;

  // Transfer flags captured at the negedge, consumed by the driver after the posedge.
  logic       wr_x = 1'b0, mo_addr_x = 1'b0, mo_data_x = 1'b0;
  logic [7:0] mo_addr_cap = 8'h00;

  function automatic logic rnd_go();
    return !stall_en || ($urandom_range(0, 3) != 0);
  endfunction

  // ---------------- driver: readies, write source, memory model ----------------
  logic       mem_pend;
  logic [7:0] mem_data;
  initial begin
    mi_addr_ready = 1'b0; mi_data_ready = 1'b0; mo_addr_ready = 1'b0; rd_ready = 1'b0;
    wr_valid = 1'b0; wr_data = 8'h00; mo_data_valid = 1'b0; mo_data = 8'h00;
    mem_pend = 1'b0; mem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!drv_en) begin
        mi_addr_ready = 1'b0; mi_data_ready = 1'b0; mo_addr_ready = 1'b0; rd_ready = 1'b0;
        wr_valid = 1'b0; mo_data_valid = 1'b0; mem_pend = 1'b0;
        wr_idx = wr_src_q.size();
      end else begin
        mi_addr_ready = rnd_go();
        mi_data_ready = rnd_go();
        mo_addr_ready = rnd_go();
        rd_ready      = rnd_go();
        if (wr_x) begin
          wr_valid = 1'b0;
          wr_idx++;
        end
        if (!wr_valid && wr_idx < wr_src_q.size() && rnd_go()) begin
          wr_valid = 1'b1;
          wr_data  = wr_src_q[wr_idx];
        end
        if (mo_data_x) mo_data_valid = 1'b0;
        if (mo_addr_x) begin
          mem_pend = 1'b1;
          mem_data = mo_addr_cap ^ 8'hFF;
        end
        if (mem_pend && !mo_data_valid && rnd_go()) begin
          mo_data_valid = 1'b1;
          mo_data       = mem_data;
          mem_pend      = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       hold_wa = 1'b0, hold_wd = 1'b0, hold_ra = 1'b0, hold_rd = 1'b0;
  logic [7:0] hold_wa_v, hold_wd_v, hold_ra_v, hold_rd_v;

  task automatic spurious(input string name, input logic [7:0] v);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected transfer of %0h, expected none", name, v);
  endtask

  always @(negedge clk) begin
    wr_x        = wr_valid && wr_ready;
    mo_addr_x   = mo_addr_valid && mo_addr_ready;
    mo_data_x   = mo_data_valid && mo_data_ready;
    mo_addr_cap = mo_addr;
    if (!mon_en) begin
      wa_idx = exp_wa_q.size(); wd_idx = exp_wd_q.size();
      ra_idx = exp_ra_q.size(); rd_idx = exp_rd_q.size();
      hold_wa = 1'b0; hold_wd = 1'b0; hold_ra = 1'b0; hold_rd = 1'b0;
    end else begin
      if (hold_wa) begin
        check("mi_addr_valid_held", {31'd0, mi_addr_valid}, 32'd1);
        check("mi_addr_stable", {24'd0, mi_addr}, {24'd0, hold_wa_v});
      end
      if (hold_wd) begin
        check("mi_data_valid_held", {31'd0, mi_data_valid}, 32'd1);
        check("mi_data_stable", {24'd0, mi_data}, {24'd0, hold_wd_v});
      end
      if (hold_ra) begin
        check("mo_addr_valid_held", {31'd0, mo_addr_valid}, 32'd1);
        check("mo_addr_stable", {24'd0, mo_addr}, {24'd0, hold_ra_v});
      end
      if (hold_rd) begin
        check("rd_valid_held", {31'd0, rd_valid}, 32'd1);
        check("rd_data_stable", {24'd0, rd_data}, {24'd0, hold_rd_v});
      end
      if (busy) check("cmd_ready_while_busy", {31'd0, cmd_ready}, 32'd0);

      if (mi_addr_valid && mi_addr_ready) begin
        if (wa_idx < exp_wa_q.size()) begin
          check("mi_addr", {24'd0, mi_addr}, {24'd0, exp_wa_q[wa_idx]});
          wa_idx++;
        end else spurious("mi_addr", mi_addr);
        log_a.push_back(mi_addr);
        n_wa++;
      end
      if (mi_data_valid && mi_data_ready) begin
        check("mi_addr_before_data", n_wa, n_wd + 1);
        if (wd_idx < exp_wd_q.size()) begin
          check("mi_data", {24'd0, mi_data}, {24'd0, exp_wd_q[wd_idx]});
          wd_idx++;
        end else spurious("mi_data", mi_data);
        log_d.push_back(mi_data);
        n_wd++;
      end
      if (mo_addr_valid && mo_addr_ready) begin
        if (ra_idx < exp_ra_q.size()) begin
          check("mo_addr", {24'd0, mo_addr}, {24'd0, exp_ra_q[ra_idx]});
          ra_idx++;
        end else spurious("mo_addr", mo_addr);
        log_a.push_back(mo_addr);
      end
      if (rd_valid && rd_ready) begin
        if (rd_idx < exp_rd_q.size()) begin
          check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd_q[rd_idx]});
          rd_idx++;
        end else spurious("rd_data", rd_data);
        log_d.push_back(rd_data);
        n_rd++;
      end

      hold_wa = mi_addr_valid && !mi_addr_ready; hold_wa_v = mi_addr;
      hold_wd = mi_data_valid && !mi_data_ready; hold_wd_v = mi_data;
      hold_ra = mo_addr_valid && !mo_addr_ready; hold_ra_v = mo_addr;
      hold_rd = rd_valid && !rd_ready;           hold_rd_v = rd_data;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_cmd(input vec_t v);
    logic [7:0] a;
    int k;
    @(posedge clk);
    #1;
    for (int j = 0; j <= int'(v.len); j++) begin
      a = v.addr + 8'(j);
      if (v.write) begin
        exp_wa_q.push_back(a);
        exp_wd_q.push_back(v.dbase + 8'(j));
        wr_src_q.push_back(v.dbase + 8'(j));
      end else begin
        exp_ra_q.push_back(a);
        exp_rd_q.push_back(a ^ 8'hFF);
      end
    end
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 200) begin
      n_vec++; n_err++;
      $display("FAIL cmd_accept_timeout: got no cmd transfer, expected one within 200 cycles");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int sa, sd, cyc, k;
    stall_en = v.stall;
    sa = log_a.size();
    sd = log_d.size();
    send_cmd(v);
    cyc = 0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    check({tag, "_done_in_budget"}, {31'd0, busy}, 32'd0);
    if (v.cycles != 0) check({tag, "_busy_cycles"}, cyc, v.cycles);
    check({tag, "_addr_beats"}, log_a.size() - sa, int'(v.len) + 1);
    check({tag, "_data_beats"}, log_d.size() - sd, int'(v.len) + 1);
    if (log_a.size() > sa) begin
      check({tag, "_first_addr"}, {24'd0, log_a[sa]}, {24'd0, v.addr});
      check({tag, "_last_addr"}, {24'd0, log_a[log_a.size()-1]}, {24'd0, v.last_addr});
    end
    if (log_d.size() > sd) begin
      check({tag, "_first_data"}, {24'd0, log_d[sd]}, {24'd0, v.first_d});
      check({tag, "_last_data"}, {24'd0, log_d[log_d.size()-1]}, {24'd0, v.last_d});
    end
    check({tag, "_cmd_ready_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_mi_addr_valid"}, {31'd0, mi_addr_valid}, 32'd0);
    check({tag, "_mi_data_valid"}, {31'd0, mi_data_valid}, 32'd0);
    check({tag, "_mo_addr_valid"}, {31'd0, mo_addr_valid}, 32'd0);
    check({tag, "_mo_data_ready"}, {31'd0, mo_data_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_mi_addr"}, {24'd0, mi_addr}, 32'd0);
    check({tag, "_mi_data"}, {24'd0, mi_data}, 32'd0);
    check({tag, "_mo_addr"}, {24'd0, mo_addr}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    int k, base;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;

    //            write  addr   len    dbase  last   first  last_d cyc stall
    vecs[0] = '{1'b1, 8'hC8, 4'd0,  8'h5A, 8'hC8, 8'h5A, 8'h5A, 3,  1'b0};
    vecs[1] = '{1'b0, 8'hC8, 4'd8,  8'h00, 8'hD0, 8'h37, 8'h2F, 27, 1'b0};
    vecs[2] = '{1'b1, 8'hFE, 4'd3,  8'h10, 8'h01, 8'h10, 8'h13, 12, 1'b0};
    vecs[3] = '{1'b0, 8'hFE, 4'd3,  8'h00, 8'h01, 8'h01, 8'hFE, 12, 1'b0};
    vecs[4] = '{1'b1, 8'h20, 4'd15, 8'hA0, 8'h2F, 8'hA0, 8'hAF, 0,  1'b1};
    vecs[5] = '{1'b0, 8'hF0, 4'd15, 8'h00, 8'hFF, 8'h0F, 8'h00, 0,  1'b1};
    vecs[6] = '{1'b0, 8'hC8, 4'd8,  8'h00, 8'hD0, 8'h37, 8'h2F, 0,  1'b1};
    vecs[7] = '{1'b1, 8'h7F, 4'd1,  8'h33, 8'h80, 8'h33, 8'h34, 0,  1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");

    rst_n = 1'b1;
    drv_en = 1'b1;
    #1;
    check("cmd_ready_before_first_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("cmd_ready_after_first_edge", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during beat 2 of a 4-beat read.
    stall_en = 1'b0;
    base = n_rd;
    rv = '{1'b0, 8'h40, 4'd3, 8'h00, 8'h43, 8'hBF, 8'hBC, 0, 1'b0};
    send_cmd(rv);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_rd - base >= 1) break;
    end
    check("mid_reset_beat1_seen", n_rd - base, 1);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    drv_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_quiet("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_hold");
    rst_n  = 1'b1;
    drv_en = 1'b1;
    #1;
    check("cmd_ready_release_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("cmd_ready_release_after_edge", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1'b1;
    rv = '{1'b0, 8'h55, 4'd0, 8'h00, 8'h55, 8'hAA, 8'hAA, 3, 1'b0};
    run_vec(rv, "post_reset_read");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
